// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch stage with IF/ID register, stall hold buffer and delay-slot branch redirect
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        id_stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_addr,
  output logic [31:0] output_addr,
  output logic [31:0] output_inst,
  output logic        output_valid
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_addr_q, hold_inst_q;
  logic        redir_valid_q;
  logic [31:0] redir_addr_q;
  logic [31:0] out_addr_q, out_inst_q;
  logic        out_valid_q;
  logic        br_take;
  assign br_take = branch_valid && out_valid_q && !id_stall;
  // a taken branch beats a pending redirect; otherwise sequential fetch
  assign pc_d = br_take ? branch_addr : redir_valid_q ? redir_addr_q : pc_q + 32'd4;
  assign inst_req     = (state_q == FETCH) && !rst;
  assign inst_addr    = pc_q;
  assign output_addr  = out_addr_q;
  assign output_inst  = out_inst_q;
  assign output_valid = out_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_addr_q   <= '0;
      hold_inst_q   <= '0;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= '0;
      out_addr_q    <= '0;
      out_inst_q    <= '0;
      out_valid_q   <= 1'b0;
    end else if (state_q == FETCH) begin
      if (inst_ack) begin
        pc_q          <= pc_d;
        redir_valid_q <= 1'b0;
        if (!id_stall) begin
          out_addr_q  <= pc_q;
          out_inst_q  <= inst_rdata;
          out_valid_q <= 1'b1;
        end else begin
          hold_addr_q <= pc_q;
          hold_inst_q <= inst_rdata;
          state_q     <= HOLD;
        end
      end else begin
        if (!id_stall) begin
          out_inst_q  <= '0;
          out_valid_q <= 1'b0;
        end
        // delay slot still in flight: remember the target until it returns
        if (br_take) begin
          redir_valid_q <= 1'b1;
          redir_addr_q  <= branch_addr;
        end
      end
    end else if (!id_stall) begin
      out_addr_q  <= hold_addr_q;
      out_inst_q  <= hold_inst_q;
      out_valid_q <= 1'b1;
      state_q     <= FETCH;
      if (br_take) pc_q <= pc_d;
    end
  end
endmodule
